// File: rtl/eh2_pkg.sv
// ============================================================================
// Module      : eh2_pkg
// Description : Shared types for the DCCM store write buffer. Provides the
//               buffer entry record used by the top level and the forwarding
//               CAM.
// Contents    : EH2_DCCM_BITS, EH2_DCCM_FDATA_WIDTH -- entry field widths
//               eh2_dccm_wrbuf_entry_t                -- {valid, addr, data}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eh2_pkg;

  // Entry field widths; the write buffer's width parameters default to these.
  localparam int unsigned EH2_DCCM_BITS        = 16;
  localparam int unsigned EH2_DCCM_FDATA_WIDTH = 39;

  typedef struct packed {
    logic                            valid;
    logic [EH2_DCCM_BITS-1:0]        addr;
    logic [EH2_DCCM_FDATA_WIDTH-1:0] data;
  } eh2_dccm_wrbuf_entry_t;

endpackage : eh2_pkg

`default_nettype wire

// File: rtl/eh2_dccm_wrbuf_fwd.sv
// ============================================================================
// Module      : eh2_dccm_wrbuf_fwd
// Description : Combinational age-priority CAM. Compares a load word address
//               against every valid buffer entry and returns the data of the
//               youngest match.
// Ports       : entries  in  buffer entry array
//               rd_ptr   in  read pointer (head = oldest entry)
//               ld_addr  in  load byte address; [1:0] ignored
//               fwd_hit  out some valid entry matches
//               fwd_data out youngest matching data, 0 when no hit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eh2_dccm_wrbuf_fwd
  import eh2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  eh2_dccm_wrbuf_entry_t            entries [DEPTH],
  input  logic [$clog2(DEPTH):0]           rd_ptr,
  input  logic [EH2_DCCM_BITS-1:0]         ld_addr,
  output logic                             fwd_hit,
  output logic [EH2_DCCM_FDATA_WIDTH-1:0]  fwd_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] idx;
  logic             unused_ld_byte;

  // Byte offset within the word never takes part in the compare.
  assign unused_ld_byte = ^ld_addr[1:0];

  // Walk from the oldest slot (rd_ptr) towards the youngest; a later match
  // overwrites an earlier one, so the youngest matching store wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr[IDX_W-1:0] + IDX_W'(i);
      if (entries[idx].valid &&
          (entries[idx].addr[EH2_DCCM_BITS-1:2] == ld_addr[EH2_DCCM_BITS-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

endmodule : eh2_dccm_wrbuf_fwd

`default_nettype wire

// File: rtl/eh2_dccm_wr_buf.sv
// ============================================================================
// Module      : eh2_dccm_wr_buf
// Description : Store write buffer in front of the DCCM write port. Queues
//               committed stores and drains them in cycles the load pipe does
//               not need the port, unless the head has starved, the buffer is
//               full, or a fence is draining it. Forwards buffered store data
//               to same-word loads.
// Ports       : clk, rst                      clock, sync active-high reset
//               st_valid/st_ready/st_addr/st_data   store enqueue
//               ld_rden, ld_addr              load port request / address
//               fwd_hit, fwd_data             store-to-load forwarding
//               fence_req                     drain everything at priority
//               dccm_rd_stall                 load pipe must hold off
//               dccm_wren, dccm_wr_addr_lo/hi, dccm_wr_data_lo/hi  DCCM write
//               buf_empty                     no valid entries
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eh2_dccm_wr_buf
  import eh2_pkg::*;
#(
  parameter int DCCM_BITS        = EH2_DCCM_BITS,
  parameter int DCCM_FDATA_WIDTH = EH2_DCCM_FDATA_WIDTH,
  parameter int DEPTH            = 4,
  parameter int STARVE_MAX       = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        st_valid,
  output logic                        st_ready,
  input  logic [DCCM_BITS-1:0]        st_addr,
  input  logic [DCCM_FDATA_WIDTH-1:0] st_data,
  input  logic                        ld_rden,
  input  logic [DCCM_BITS-1:0]        ld_addr,
  output logic                        fwd_hit,
  output logic [DCCM_FDATA_WIDTH-1:0] fwd_data,
  input  logic                        fence_req,
  output logic                        dccm_rd_stall,
  output logic                        dccm_wren,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
  output logic                        buf_empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  eh2_dccm_wrbuf_entry_t entries [DEPTH];
  eh2_dccm_wrbuf_entry_t head;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] starve_cnt;

  logic full;
  logic empty;
  logic force_drain;
  logic enq;
  logic pop;
  logic cam_hit;
  logic [DCCM_FDATA_WIDTH-1:0] cam_data;
  logic unused_head_valid;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign force_drain = full | fence_req | (starve_cnt == CNT_W'(STARVE_MAX));

  // Outputs are held quiet during reset so a stale head can never be written.
  assign st_ready      = !rst && !full;
  assign dccm_wren     = !rst && !empty && (!ld_rden || force_drain);
  assign dccm_rd_stall = !rst && !empty && force_drain;
  assign buf_empty     = rst || empty;

  assign enq = st_valid && st_ready;
  assign pop = dccm_wren;

  // Head drives the write port directly; only aligned word stores are
  // buffered, so both halves carry the same address and data.
  assign head              = entries[rd_ptr[IDX_W-1:0]];
  assign unused_head_valid = head.valid;
  assign dccm_wr_addr_lo   = head.addr;
  assign dccm_wr_addr_hi   = head.addr;
  assign dccm_wr_data_lo   = head.data;
  assign dccm_wr_data_hi   = head.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      // enq and pop never hit the same slot: that needs empty (no pop)
      // or full (no enq).
      if (enq) begin
        entries[wr_ptr[IDX_W-1:0]] <= '{valid: 1'b1, addr: st_addr, data: st_data};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        entries[rd_ptr[IDX_W-1:0]].valid <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop || empty) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  eh2_dccm_wrbuf_fwd #(
    .DEPTH (DEPTH)
  ) u_fwd (
    .entries  (entries),
    .rd_ptr   (rd_ptr),
    .ld_addr  (ld_addr),
    .fwd_hit  (cam_hit),
    .fwd_data (cam_data)
  );

  assign fwd_hit  = !rst && cam_hit;
  assign fwd_data = (!rst && cam_hit) ? cam_data : '0;

endmodule : eh2_dccm_wr_buf

`default_nettype wire

// File: tb/tb_eh2_dccm_wr_buf.sv
// ============================================================================
// Module      : tb_eh2_dccm_wr_buf
// Description : Self-checking bench for eh2_dccm_wr_buf. Every store driven is
//               pushed to an expected-write queue; a negedge monitor pops and
//               compares each DCCM write. Scenario tasks check control and
//               forwarding outputs inline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_eh2_dccm_wr_buf;

  localparam int AW = 16;
  localparam int DW = 39;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic          ld_rden = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          fence_req = 1'b0;
  logic          dccm_rd_stall;
  logic          dccm_wren;
  logic [AW-1:0] dccm_wr_addr_lo;
  logic [AW-1:0] dccm_wr_addr_hi;
  logic [DW-1:0] dccm_wr_data_lo;
  logic [DW-1:0] dccm_wr_data_hi;
  logic          buf_empty;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  eh2_dccm_wr_buf #(
    .DCCM_BITS        (AW),
    .DCCM_FDATA_WIDTH (DW),
    .DEPTH            (4),
    .STARVE_MAX       (7)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .st_valid        (st_valid),
    .st_ready        (st_ready),
    .st_addr         (st_addr),
    .st_data         (st_data),
    .ld_rden         (ld_rden),
    .ld_addr         (ld_addr),
    .fwd_hit         (fwd_hit),
    .fwd_data        (fwd_data),
    .fence_req       (fence_req),
    .dccm_rd_stall   (dccm_rd_stall),
    .dccm_wren       (dccm_wren),
    .dccm_wr_addr_lo (dccm_wr_addr_lo),
    .dccm_wr_addr_hi (dccm_wr_addr_hi),
    .dccm_wr_data_lo (dccm_wr_data_lo),
    .dccm_wr_data_hi (dccm_wr_data_hi),
    .buf_empty       (buf_empty)
  );

  // Scoreboard: every DCCM write must match the oldest outstanding store.
  always @(negedge clk) begin : sb
    wr_t e;
    if (dccm_wren === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write: got addr=%h data=%h, expected no write",
                 dccm_wr_addr_lo, dccm_wr_data_lo);
      end else begin
        e = exp_q.pop_front();
        if (dccm_wr_addr_lo !== e.addr || dccm_wr_addr_hi !== e.addr ||
            dccm_wr_data_lo !== e.data || dccm_wr_data_hi !== e.data) begin
          errors++;
          $display("FAIL sb_write: got lo=%h/%h hi=%h/%h, expected %h/%h",
                   dccm_wr_addr_lo, dccm_wr_data_lo, dccm_wr_addr_hi,
                   dccm_wr_data_hi, e.addr, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rnd_data();
    return {7'($urandom), 32'($urandom)};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    exp_q.push_back('{addr: a, data: d});
  endtask

  // Drain with ld_rden low; returns once buf_empty is seen (ends after a tick).
  task automatic wait_empty(input int max_cyc, output bit ok);
    ok = 1'b0;
    ld_rden = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (buf_empty === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    tick();
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b0 || dccm_wren !== 1'b0 || dccm_rd_stall !== 1'b0 ||
        fwd_hit !== 1'b0 || buf_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b wren=%b stall=%b hit=%b empty=%b, expected 0 0 0 0 1",
               st_ready, dccm_wren, dccm_rd_stall, fwd_hit, buf_empty);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b1 || buf_empty !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: got rdy=%b empty=%b, expected 1 1", st_ready, buf_empty);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [DW-1:0] d0;
    d0 = rnd_data();
    ld_rden = 1'b0;
    put_store(16'h0100, d0);
    @(negedge clk);
    checks++;
    if (dccm_wren !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: got wren=%b, expected 0", dccm_wren);
    end
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dccm_wren !== 1'b1 || dccm_wr_addr_lo !== 16'h0100 ||
        dccm_wr_addr_hi !== 16'h0100 || dccm_wr_data_lo !== d0 || dccm_wr_data_hi !== d0) begin
      errors++;
      $display("FAIL basic_write: got wren=%b addr=%h/%h data=%h, expected 1 0100 %h",
               dccm_wren, dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_wr_data_lo, d0);
    end
    tick();
    @(negedge clk);
    checks++;
    if (buf_empty !== 1'b1) begin
      errors++;
      $display("FAIL basic_empty: got %b, expected 1", buf_empty);
    end
    tick();
  endtask

  task automatic test_full();
    bit ok;
    ld_rden = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put_store(16'h0300 + 16'(4 * i), rnd_data());
      @(negedge clk);
      checks++;
      if (st_ready !== 1'b1 || dccm_wren !== 1'b0) begin
        errors++;
        $display("FAIL full_fill%0d: got rdy=%b wren=%b, expected 1 0", i, st_ready, dccm_wren);
      end
      tick();
    end
    st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b0 || dccm_wren !== 1'b1 || dccm_rd_stall !== 1'b1) begin
      errors++;
      $display("FAIL full_force: got rdy=%b wren=%b stall=%b, expected 0 1 1",
               st_ready, dccm_wren, dccm_rd_stall);
    end
    tick();
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b1 || dccm_wren !== 1'b0) begin
      errors++;
      $display("FAIL full_after_pop: got rdy=%b wren=%b, expected 1 0", st_ready, dccm_wren);
    end
    tick();
    wait_empty(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_drain_timeout: buf_empty never rose, expected within 20 cycles");
    end
  endtask

  task automatic test_starve();
    ld_rden = 1'b1;
    put_store(16'h0400, rnd_data());
    tick();
    st_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (dccm_wren !== 1'b0 || dccm_rd_stall !== 1'b0) begin
        errors++;
        $display("FAIL starve_wait%0d: got wren=%b stall=%b, expected 0 0", k, dccm_wren, dccm_rd_stall);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (dccm_wren !== 1'b1 || dccm_rd_stall !== 1'b1) begin
      errors++;
      $display("FAIL starve_force: got wren=%b stall=%b, expected 1 1", dccm_wren, dccm_rd_stall);
    end
    tick();
    ld_rden = 1'b0;
    @(negedge clk);
    checks++;
    if (buf_empty !== 1'b1) begin
      errors++;
      $display("FAIL starve_empty: got %b, expected 1", buf_empty);
    end
    tick();
  endtask

  task automatic test_forward();
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    da = rnd_data();
    db = rnd_data();
    ld_rden = 1'b1;
    ld_addr = 16'h0202;
    put_store(16'h0200, da);
    @(negedge clk);
    checks++;
    if (fwd_hit !== 1'b0 || fwd_data !== '0) begin
      errors++;
      $display("FAIL fwd_enq_same_cycle: got hit=%b data=%h, expected 0 0", fwd_hit, fwd_data);
    end
    tick();
    put_store(16'h0200, db);
    @(negedge clk);
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== da) begin
      errors++;
      $display("FAIL fwd_first: got hit=%b data=%h, expected 1 %h", fwd_hit, fwd_data, da);
    end
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== db) begin
      errors++;
      $display("FAIL fwd_youngest: got hit=%b data=%h, expected 1 %h", fwd_hit, fwd_data, db);
    end
    tick();
    ld_addr = 16'h0204;
    @(negedge clk);
    checks++;
    if (fwd_hit !== 1'b0 || fwd_data !== '0) begin
      errors++;
      $display("FAIL fwd_miss: got hit=%b data=%h, expected 0 0", fwd_hit, fwd_data);
    end
    tick();
    ld_addr = 16'h0202;
    ld_rden = 1'b0;
    @(negedge clk);
    checks++;
    if (dccm_wren !== 1'b1 || fwd_hit !== 1'b1 || fwd_data !== db) begin
      errors++;
      $display("FAIL fwd_pop_a: got wren=%b hit=%b data=%h, expected 1 1 %h",
               dccm_wren, fwd_hit, fwd_data, db);
    end
    tick();
    @(negedge clk);
    checks++;
    if (dccm_wren !== 1'b1 || fwd_hit !== 1'b1 || fwd_data !== db) begin
      errors++;
      $display("FAIL fwd_pop_b: got wren=%b hit=%b data=%h, expected 1 1 %h",
               dccm_wren, fwd_hit, fwd_data, db);
    end
    tick();
    @(negedge clk);
    checks++;
    if (buf_empty !== 1'b1 || fwd_hit !== 1'b0 || fwd_data !== '0) begin
      errors++;
      $display("FAIL fwd_drained: got empty=%b hit=%b data=%h, expected 1 0 0",
               buf_empty, fwd_hit, fwd_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int  nwr;
    bit  ok;
    ld_rden = 1'b1;
    put_store(16'h0500, rnd_data());
    tick();
    put_store(16'h0504, rnd_data());
    tick();
    // count=2: pop the head while enqueueing a third store
    ld_rden = 1'b0;
    put_store(16'h0508, rnd_data());
    @(negedge clk);
    checks++;
    if (dccm_wren !== 1'b1 || st_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_same_cycle: got wren=%b rdy=%b, expected 1 1", dccm_wren, st_ready);
    end
    tick();
    // If count stayed 2, exactly two more stores fill the buffer.
    ld_rden = 1'b1;
    put_store(16'h050C, rnd_data());
    tick();
    put_store(16'h0510, rnd_data());
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count_rdy: got rdy=%b, expected 1", st_ready);
    end
    tick();
    st_valid  = 1'b0;
    fence_req = 1'b1;
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count_full: got rdy=%b, expected 0", st_ready);
    end
    nwr = 0;
    ok  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge clk);
      if (buf_empty === 1'b1) begin
        ok = 1'b1;
        break;
      end
      checks++;
      if (dccm_rd_stall !== 1'b1 || dccm_wren !== 1'b1) begin
        errors++;
        $display("FAIL fence_drain%0d: got stall=%b wren=%b, expected 1 1", c, dccm_rd_stall, dccm_wren);
      end
      nwr++;
      tick();
    end
    checks++;
    if (!ok || nwr != 4) begin
      errors++;
      $display("FAIL fence_count: got empty=%b writes=%0d, expected 1 4", ok, nwr);
    end
    tick();
    fence_req = 1'b0;
    ld_rden   = 1'b0;
  endtask

  task automatic test_reset_mid();
    ld_rden = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put_store(16'h0600 + 16'(4 * i), rnd_data());
      tick();
    end
    st_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (buf_empty !== 1'b1 || dccm_wren !== 1'b0 || st_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got empty=%b wren=%b rdy=%b, expected 1 0 0",
               buf_empty, dccm_wren, st_ready);
    end
    tick();
    rst = 1'b0;
    ld_rden = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (dccm_wren !== 1'b0 || buf_empty !== 1'b1) begin
        errors++;
        $display("FAIL rst_stale%0d: got wren=%b empty=%b, expected 0 1", k, dccm_wren, buf_empty);
      end
      tick();
    end
  endtask

  initial begin : main
    test_reset();
    test_basic();
    test_full();
    test_starve();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending writes, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_eh2_dccm_wr_buf

`default_nettype wire
